// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared types for the BF16 MAC array front end.
//   BF16_W         : width of one BF16 operand
//   bf16_t         : one BF16 operand
//   feeder_state_t : operand feeder control states
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int BF16_W = 16;

    typedef logic [BF16_W-1:0] bf16_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/mac_feeder_fifo.sv
// -----------------------------------------------------------------------------
// mac_feeder_fifo
// Synchronous FIFO with show-ahead read data, used to buffer operand vectors.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count only)
//   push,wdata : write request and data; ignored while full
//   pop        : read request; ignored while empty
//   rdata      : entry at the head of the FIFO (valid while not empty)
//   full,empty : occupancy flags derived from the registered count
//   count      : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module mac_feeder_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop while full does not make room for a push in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_row_feeder.sv
// -----------------------------------------------------------------------------
// mac_row_feeder
// Operand feeder for the BF16 MAC array: buffers ROWS-wide operand vectors in a
// FIFO and drives the array rows with diagonal skew (row r delayed r cycles).
// A vector flagged last ends the tile: pops stop while the skew pipeline
// drains, and done pulses when that vector's row ROWS-1 operand is on op_out.
// Optional feature macro: MAC_FEEDER_STALL_CNT_EN adds the stall_cnt port.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : producer handshake (in_ready = FIFO not full)
//   in_data, in_last  : operand vector (row r at [r*16 +: 16]) and tile end
//   op_out, op_valid  : skewed operands and per-row valids to the array
//   busy              : not IDLE or FIFO holds data
//   done              : one-cycle end-of-tile pulse
//   stall_cnt         : saturating count of STREAM cycles with FIFO empty
// -----------------------------------------------------------------------------
module mac_row_feeder
    import mac_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*BF16_W-1:0] in_data,
    input  logic                   in_last,
    output logic [ROWS*BF16_W-1:0] op_out,
    output logic [ROWS-1:0]        op_valid,
    output logic                   busy,
    output logic                   done
`ifdef MAC_FEEDER_STALL_CNT_EN
   ,output logic [31:0]            stall_cnt
`endif
);

    localparam int FW = ROWS*BF16_W + 1;
    localparam int CW = $clog2(ROWS) + 1;

    feeder_state_t           state;
    feeder_state_t           state_next;
    logic [CW-1:0]           drain_cnt;
    logic [CW-1:0]           drain_cnt_next;
    logic                    done_next;

    logic [FW-1:0]           fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    pop;
    logic                    pop_last;
    logic [ROWS*BF16_W-1:0]  pop_data;

    mac_feeder_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata ({in_last, in_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign pop      = !fifo_empty && ((state == IDLE) || (state == STREAM));
    assign pop_last = fifo_rdata[FW-1];
    assign pop_data = fifo_rdata[FW-2:0];

    // Control: state, drain down-counter, registered done
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next     = pop_last ? DRAIN : STREAM;
                    drain_cnt_next = CW'(ROWS-1);
                end
            end
            STREAM: begin
                if (pop && pop_last) begin
                    state_next     = DRAIN;
                    drain_cnt_next = CW'(ROWS-1);
                end
            end
            DRAIN: begin
                // done is registered, so it is raised one cycle ahead of the
                // final drain cycle (count 0) to land on that cycle.
                done_next = (drain_cnt == CW'(1));
                if (drain_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    drain_cnt_next = drain_cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            done      <= done_next;
        end
    end

    // Skew pipeline: row r owns r+1 stages; stage _p[0] takes the popped
    // element (or a zero bubble), the row output is its last stage.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        bf16_t skew_dat_p [r+1];
        logic  skew_vld_p [r+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) begin
                    skew_dat_p[k] <= '0;
                    skew_vld_p[k] <= 1'b0;
                end
            end else begin
                skew_dat_p[0] <= pop ? pop_data[r*BF16_W +: BF16_W] : '0;
                skew_vld_p[0] <= pop;
                for (int k = 1; k <= r; k++) begin
                    skew_dat_p[k] <= skew_dat_p[k-1];
                    skew_vld_p[k] <= skew_vld_p[k-1];
                end
            end
        end

        assign op_out[r*BF16_W +: BF16_W] = skew_dat_p[r];
        assign op_valid[r]                = skew_vld_p[r];
    end

`ifdef MAC_FEEDER_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == STREAM) && fifo_empty) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule
